// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// State encodings are also exported on state_dbg, so they are fixed values.
package pll_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_PLL_RST     = 3'd0,
    S_WAIT_LOCK   = 3'd1,
    S_LOCK_STABLE = 3'd2,
    S_RELEASE     = 3'd3,
    S_RUN         = 3'd4,
    S_FAULT       = 3'd5
  } seq_state_t;

  // Timer must hold the longest interval any state measures, plus headroom.
  function automatic int tmr_width(int lock_timeout, int stage_span,
                                   int pll_rst_cycles, int lock_stable_cycles);
    int m;
    m = lock_timeout;
    if (stage_span > m)         m = stage_span;
    if (pll_rst_cycles > m)     m = pll_rst_cycles;
    if (lock_stable_cycles > m) m = lock_stable_cycles;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs.
// Both stages reset to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and staged fabric reset release with lock qualification,
// bounded retry on lock timeout and full resequence on lock loss.
//
// state         | meaning
// S_PLL_RST     | PLL held in reset for PLL_RST_CYCLES
// S_WAIT_LOCK   | PLL running, waiting for synchronised lock (timeout/retry)
// S_LOCK_STABLE | lock seen, requiring LOCK_STABLE_CYCLES clean cycles
// S_RELEASE     | domains released one by one, STAGE_GAP apart
// S_RUN         | all domains released, ready
// S_FAULT       | retries exhausted, sticky until soft_rst_req or rst_n
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int N_DOMAINS          = 3,
  parameter int PLL_RST_CYCLES     = 4,
  parameter int LOCK_TIMEOUT       = 64,
  parameter int LOCK_STABLE_CYCLES = 8,
  parameter int STAGE_GAP          = 4,
  parameter int MAX_RETRIES        = 2,
  parameter int CNT_W              = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_lock,
  input  logic                 soft_rst_req,
  output logic                 pll_rst_n,
  output logic [N_DOMAINS-1:0] domain_rst_n,
  output logic                 ready,
  output logic                 fault,
  output logic [STATE_W-1:0]   state_dbg,
  output logic [CNT_W-1:0]     retry_count,
  output logic [CNT_W-1:0]     lock_loss_count
);

  localparam int TMR_W = tmr_width(LOCK_TIMEOUT, STAGE_GAP * (N_DOMAINS + 1),
                                   PLL_RST_CYCLES, LOCK_STABLE_CYCLES);

  localparam logic [TMR_W-1:0] TC_PLL_RST = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TC_TIMEOUT = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TC_STABLE  = TMR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TC_RELEASE = TMR_W'(STAGE_GAP * N_DOMAINS);
  localparam logic [CNT_W-1:0] RETRY_MAX  = CNT_W'(MAX_RETRIES);

  logic w_lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pll_lock),
    .o_q   (w_lock_s)
  );

  seq_state_t           r_state;
  seq_state_t           w_state_nxt;
  logic [TMR_W-1:0]     r_tmr;
  logic [TMR_W-1:0]     w_tmr_nxt;
  logic [CNT_W-1:0]     r_retry;
  logic [CNT_W-1:0]     w_retry_nxt;
  logic [CNT_W-1:0]     r_loss;
  logic                 w_loss_inc;

  logic                 r_pll_rst_n;
  logic                 w_pll_rst_n_nxt;
  logic [N_DOMAINS-1:0] r_dom;
  logic [N_DOMAINS-1:0] w_dom_nxt;
  logic                 r_ready;
  logic                 w_ready_nxt;
  logic                 r_fault;
  logic                 w_fault_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_PLL_RST;
      r_tmr       <= '0;
      r_retry     <= '0;
      r_loss      <= '0;
      r_pll_rst_n <= 1'b0;
      r_dom       <= '0;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tmr       <= w_tmr_nxt;
      r_retry     <= w_retry_nxt;
      if (w_loss_inc && (r_loss != {CNT_W{1'b1}})) begin
        r_loss <= r_loss + CNT_W'(1);
      end
      r_pll_rst_n <= w_pll_rst_n_nxt;
      r_dom       <= w_dom_nxt;
      r_ready     <= w_ready_nxt;
      r_fault     <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr + TMR_W'(1);
    w_retry_nxt = r_retry;
    w_loss_inc  = 1'b0;

    case (r_state)
      S_PLL_RST: begin
        if (soft_rst_req) begin
          w_tmr_nxt = '0;
        end else if (r_tmr == TC_PLL_RST) begin
          w_state_nxt = S_WAIT_LOCK;
          w_tmr_nxt   = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = S_LOCK_STABLE;
          w_tmr_nxt   = '0;
        end else if (r_tmr == TC_TIMEOUT) begin
          w_tmr_nxt = '0;
          if (r_retry == RETRY_MAX) begin
            w_state_nxt = S_FAULT;
          end else begin
            w_state_nxt = S_PLL_RST;
            w_retry_nxt = r_retry + CNT_W'(1);
          end
        end
      end
      S_LOCK_STABLE: begin
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_tmr_nxt   = '0;
        end else if (r_tmr == TC_STABLE) begin
          w_state_nxt = S_RELEASE;
          w_tmr_nxt   = '0;
        end
      end
      S_RELEASE: begin
        if (r_tmr == TC_RELEASE) begin
          w_state_nxt = S_RUN;
          w_tmr_nxt   = '0;
          w_retry_nxt = '0;
        end
      end
      S_RUN: begin
        w_tmr_nxt = '0;
      end
      S_FAULT: begin
        w_tmr_nxt = '0;
      end
      default: begin
        w_state_nxt = S_PLL_RST;
        w_tmr_nxt   = '0;
      end
    endcase

    // Lock loss once domains are being released restarts everything.
    if (!w_lock_s && ((r_state == S_RELEASE) || (r_state == S_RUN))) begin
      w_loss_inc  = 1'b1;
      w_state_nxt = S_PLL_RST;
      w_tmr_nxt   = '0;
      w_retry_nxt = '0;
    end

    if (soft_rst_req && (r_state != S_PLL_RST)) begin
      w_state_nxt = S_PLL_RST;
      w_tmr_nxt   = '0;
      w_retry_nxt = '0;
    end
  end

  // Outputs are decoded from the next state so the registers line up with it.
  always_comb begin
    w_pll_rst_n_nxt = (w_state_nxt == S_WAIT_LOCK) || (w_state_nxt == S_LOCK_STABLE) ||
                      (w_state_nxt == S_RELEASE)   || (w_state_nxt == S_RUN);
    w_ready_nxt     = (w_state_nxt == S_RUN);
    w_fault_nxt     = (w_state_nxt == S_FAULT);
    w_dom_nxt       = '0;
    for (int i = 0; i < N_DOMAINS; i++) begin
      w_dom_nxt[i] = (w_state_nxt == S_RUN) ||
                     ((w_state_nxt == S_RELEASE) &&
                      (w_tmr_nxt >= TMR_W'(STAGE_GAP * (i + 1))));
    end
  end

  assign pll_rst_n       = r_pll_rst_n;
  assign domain_rst_n    = r_dom;
  assign ready           = r_ready;
  assign fault           = r_fault;
  assign state_dbg       = r_state;
  assign retry_count     = r_retry;
  assign lock_loss_count = r_loss;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer at default parameters: edge-indexed
// vector tables plus hand sequences for reset and asynchronous corner cases.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       pll_rst_n;
  logic [2:0] domain_rst_n;
  logic       ready;
  logic       fault;
  logic [2:0] state_dbg;
  logic [7:0] retry_count;
  logic [7:0] lock_loss_count;

  pll_reset_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pll_lock        (pll_lock),
    .soft_rst_req    (soft_rst_req),
    .pll_rst_n       (pll_rst_n),
    .domain_rst_n    (domain_rst_n),
    .ready           (ready),
    .fault           (fault),
    .state_dbg       (state_dbg),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clk = ~clk;

  // Vector: at edge e (+1ns) compare outputs, then drive lock/req.
  typedef struct {
    int         e;
    logic       lock;
    logic       req;
    logic       pll;
    logic [2:0] dom;
    logic       rdy;
    logic       flt;
    logic [2:0] st;
    logic [7:0] rty;
    logic [7:0] loss;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;
  int   cur   = 0;

  function automatic void add(int e, logic lk, logic rq, logic pl, logic [2:0] dm,
                              logic rd, logic fl, logic [2:0] st, logic [7:0] rt,
                              logic [7:0] ls);
    vec_t v;
    v.e = e; v.lock = lk; v.req = rq; v.pll = pl; v.dom = dm;
    v.rdy = rd; v.flt = fl; v.st = st; v.rty = rt; v.loss = ls;
    vq.push_back(v);
  endfunction

  task automatic tick_to(input int e);
    while (cur < e) begin
      @(posedge clk);
      cur++;
    end
    #1;
  endtask

  task automatic check(input string name, input int e, input logic pl,
                       input logic [2:0] dm, input logic rd, input logic fl,
                       input logic [2:0] st, input logic [7:0] rt, input logic [7:0] ls);
    tests++;
    if ({pll_rst_n, domain_rst_n, ready, fault, state_dbg, retry_count, lock_loss_count} !==
        {pl, dm, rd, fl, st, rt, ls}) begin
      fails++;
      $display("FAIL %s e%0d: got pll=%b dom=%b rdy=%b flt=%b st=%0d rty=%0d loss=%0d, want pll=%b dom=%b rdy=%b flt=%b st=%0d rty=%0d loss=%0d",
               name, e, pll_rst_n, domain_rst_n, ready, fault, state_dbg, retry_count,
               lock_loss_count, pl, dm, rd, fl, st, rt, ls);
    end
  endtask

  task automatic run_vecs(input string tag);
    foreach (vq[i]) begin
      tick_to(vq[i].e);
      check(tag, vq[i].e, vq[i].pll, vq[i].dom, vq[i].rdy, vq[i].flt, vq[i].st,
            vq[i].rty, vq[i].loss);
      pll_lock     = vq[i].lock;
      soft_rst_req = vq[i].req;
    end
    vq.delete();
  endtask

  // Called 1ns after an edge; the next edge becomes e1.
  task automatic do_reset(input logic lk);
    rst_n = 1'b0;
    soft_rst_req = 1'b0;
    pll_lock = lk;
    #2;
    rst_n = 1'b1;
    cur = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 0, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    rst_n = 1'b1;
    cur = 0;

    // Bring-up, lock loss in RUN, soft request in RUN, second release.
    add( 0,0,0, 0,3'b000,0,0,3'd0,8'd0,8'd0);
    add( 3,0,0, 0,3'b000,0,0,3'd0,8'd0,8'd0);
    add( 4,0,0, 1,3'b000,0,0,3'd1,8'd0,8'd0);
    add(14,1,0, 1,3'b000,0,0,3'd1,8'd0,8'd0);
    add(16,1,0, 1,3'b000,0,0,3'd1,8'd0,8'd0);
    add(17,1,0, 1,3'b000,0,0,3'd2,8'd0,8'd0);
    add(24,1,0, 1,3'b000,0,0,3'd2,8'd0,8'd0);
    add(25,1,0, 1,3'b000,0,0,3'd3,8'd0,8'd0);
    add(28,1,0, 1,3'b000,0,0,3'd3,8'd0,8'd0);
    add(29,1,0, 1,3'b001,0,0,3'd3,8'd0,8'd0);
    add(32,1,0, 1,3'b001,0,0,3'd3,8'd0,8'd0);
    add(33,1,0, 1,3'b011,0,0,3'd3,8'd0,8'd0);
    add(36,1,0, 1,3'b011,0,0,3'd3,8'd0,8'd0);
    add(37,1,0, 1,3'b111,0,0,3'd3,8'd0,8'd0);
    add(38,1,0, 1,3'b111,1,0,3'd4,8'd0,8'd0);
    add(40,0,0, 1,3'b111,1,0,3'd4,8'd0,8'd0);
    add(42,0,0, 1,3'b111,1,0,3'd4,8'd0,8'd0);
    add(43,1,0, 0,3'b000,0,0,3'd0,8'd0,8'd1);
    add(47,1,0, 1,3'b000,0,0,3'd1,8'd0,8'd1);
    add(48,1,0, 1,3'b000,0,0,3'd2,8'd0,8'd1);
    add(56,1,0, 1,3'b000,0,0,3'd3,8'd0,8'd1);
    add(60,1,0, 1,3'b001,0,0,3'd3,8'd0,8'd1);
    add(68,1,0, 1,3'b111,0,0,3'd3,8'd0,8'd1);
    add(69,1,0, 1,3'b111,1,0,3'd4,8'd0,8'd1);
    add(70,1,1, 1,3'b111,1,0,3'd4,8'd0,8'd1);
    add(71,1,0, 0,3'b000,0,0,3'd0,8'd0,8'd1);
    add(75,1,0, 1,3'b000,0,0,3'd1,8'd0,8'd1);
    add(76,1,0, 1,3'b000,0,0,3'd2,8'd0,8'd1);
    add(84,1,0, 1,3'b000,0,0,3'd3,8'd0,8'd1);
    add(89,1,0, 1,3'b001,0,0,3'd3,8'd0,8'd1);
    run_vecs("bringup");

    // Asynchronous reset mid-RELEASE: outputs clear before the next edge.
    rst_n = 1'b0;
    #1;
    check("async_rst", 89, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    #1;
    rst_n = 1'b1;
    cur = 0;

    // One-cycle lock glitch inside LOCK_STABLE (lock held high from reset).
    add( 0,1,0, 0,3'b000,0,0,3'd0,8'd0,8'd0);
    add( 4,1,0, 1,3'b000,0,0,3'd1,8'd0,8'd0);
    add( 5,1,0, 1,3'b000,0,0,3'd2,8'd0,8'd0);
    add( 9,0,0, 1,3'b000,0,0,3'd2,8'd0,8'd0);
    add(10,1,0, 1,3'b000,0,0,3'd2,8'd0,8'd0);
    add(11,1,0, 1,3'b000,0,0,3'd2,8'd0,8'd0);
    add(12,1,0, 1,3'b000,0,0,3'd1,8'd0,8'd0);
    add(13,1,0, 1,3'b000,0,0,3'd2,8'd0,8'd0);
    add(20,1,0, 1,3'b000,0,0,3'd2,8'd0,8'd0);
    add(21,1,0, 1,3'b000,0,0,3'd3,8'd0,8'd0);
    add(25,1,0, 1,3'b001,0,0,3'd3,8'd0,8'd0);
    run_vecs("glitch");

    // Lock never arrives: two retries, then FAULT; soft request recovers,
    // then soft request in RUN and simultaneous loss+request.
    do_reset(1'b0);
    add(  0,0,0, 0,3'b000,0,0,3'd0,8'd0,8'd0);
    add(  4,0,0, 1,3'b000,0,0,3'd1,8'd0,8'd0);
    add( 67,0,0, 1,3'b000,0,0,3'd1,8'd0,8'd0);
    add( 68,0,0, 0,3'b000,0,0,3'd0,8'd1,8'd0);
    add( 72,0,0, 1,3'b000,0,0,3'd1,8'd1,8'd0);
    add(135,0,0, 1,3'b000,0,0,3'd1,8'd1,8'd0);
    add(136,0,0, 0,3'b000,0,0,3'd0,8'd2,8'd0);
    add(140,0,0, 1,3'b000,0,0,3'd1,8'd2,8'd0);
    add(203,0,0, 1,3'b000,0,0,3'd1,8'd2,8'd0);
    add(204,0,0, 0,3'b000,0,1,3'd5,8'd2,8'd0);
    add(210,0,1, 0,3'b000,0,1,3'd5,8'd2,8'd0);
    add(211,0,1, 0,3'b000,0,0,3'd0,8'd0,8'd0);
    add(213,0,0, 0,3'b000,0,0,3'd0,8'd0,8'd0);
    add(216,0,0, 0,3'b000,0,0,3'd0,8'd0,8'd0);
    add(217,1,0, 1,3'b000,0,0,3'd1,8'd0,8'd0);
    add(220,1,0, 1,3'b000,0,0,3'd2,8'd0,8'd0);
    add(228,1,0, 1,3'b000,0,0,3'd3,8'd0,8'd0);
    add(232,1,0, 1,3'b001,0,0,3'd3,8'd0,8'd0);
    add(241,1,0, 1,3'b111,1,0,3'd4,8'd0,8'd0);
    add(243,1,1, 1,3'b111,1,0,3'd4,8'd0,8'd0);
    add(244,1,0, 0,3'b000,0,0,3'd0,8'd0,8'd0);
    add(248,1,0, 1,3'b000,0,0,3'd1,8'd0,8'd0);
    add(249,1,0, 1,3'b000,0,0,3'd2,8'd0,8'd0);
    add(257,1,0, 1,3'b000,0,0,3'd3,8'd0,8'd0);
    add(270,1,0, 1,3'b111,1,0,3'd4,8'd0,8'd0);
    add(272,0,0, 1,3'b111,1,0,3'd4,8'd0,8'd0);
    add(274,0,1, 1,3'b111,1,0,3'd4,8'd0,8'd0);
    add(275,0,1, 0,3'b000,0,0,3'd0,8'd0,8'd1);
    add(276,1,0, 0,3'b000,0,0,3'd0,8'd0,8'd1);
    add(280,1,0, 1,3'b000,0,0,3'd1,8'd0,8'd1);
    run_vecs("timeout_fault");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Parametrised clock/reset manager; next generation of our PLL pixel-clock wrapper.
- Runs on a free-running reference clock (HSOSC or LSOSC).
- Drives the PLL primitive's RESET_N and monitors its async LOCK, with lock timeout, bounded retry and lock-stability qualification.
- Releases N_DOMAINS fabric reset domains in staged order, and on lock loss re-runs the whole sequence; this replaces the ad-hoc "LOCK releases system reset" wiring.

Parameters:
- N_DOMAINS, 3, number of staged reset outputs (1..8).
- PLL_RST_CYCLES, 4, cycles pll_rst_n is held low per attempt (>=1).
- LOCK_TIMEOUT, 64, cycles to wait for synchronised lock per attempt (>=2).
- LOCK_STABLE_CYCLES, 8, consecutive lock-high cycles required before release (>=1).
- STAGE_GAP, 4, cycles between successive domain releases (>=1).
- MAX_RETRIES, 2, timeouts tolerated before FAULT (>=0).
- CNT_W, 8, width of the saturating diagnostic counters.

Ports:
- clk  in  1  free-running reference clock
- rst_n  in  1  asynchronous active-low reset
- pll_lock  in  1  PLL LOCK, asynchronous to clk
- soft_rst_req  in  1  level request to restart the sequence
- pll_rst_n  out  1  to PLL RESET_N, registered
- domain_rst_n  out  N_DOMAINS  per-domain active-low reset, registered
- ready  out  1  all domains released and lock good
- fault  out  1  retries exhausted
- state_dbg  out  3  current state encoding
- retry_count  out  CNT_W  timeouts in the current attempt series
- lock_loss_count  out  CNT_W  lock losses seen in RUN, saturating

Behaviour:
- Reset values (async on rst_n low):
  - pll_rst_n=0, domain_rst_n=all 0, ready=0, fault=0, both counters=0.
  - state=PLL_RST, all timers=0.
- Lock input: 2-flop synchroniser produces lock_s. Latency is 2 clk edges; all decisions below use lock_s only.
- PLL_RST:
  - pll_rst_n=0; timer counts PLL_RST_CYCLES cycles.
  - Then go to WAIT_LOCK; pll_rst_n=1 from the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - lock_s=1 -> LOCK_STABLE, timer cleared.
  - Timer reaches LOCK_TIMEOUT-1 with lock_s=0:
    - if retry_count==MAX_RETRIES -> FAULT;
    - else retry_count++ and go to PLL_RST.
- LOCK_STABLE:
  - lock_s held high for LOCK_STABLE_CYCLES consecutive cycles -> RELEASE.
  - Any lock_s=0 -> WAIT_LOCK with timer restarted; retry_count is not incremented.
- RELEASE:
  - Stage timer starts at 0 on entry.
  - domain_rst_n[i] rises at entry+STAGE_GAP*(i+1) cycles, in index order; bits once high stay high.
  - The cycle after domain_rst_n[N_DOMAINS-1] rises -> RUN, ready=1, retry_count cleared.
- RUN:
  - Holds all domains released.
  - lock_s=0 -> lock_loss_count++ (saturating at 2^CNT_W-1). On the next edge: domain_rst_n=all 0, ready=0, state PLL_RST, retry_count=0.
- Lock loss during RELEASE: same as in RUN (count it, drop all domains, go to PLL_RST).
- soft_rst_req=1 in any state except PLL_RST:
  - Next edge: all domains to reset, ready=0, fault=0, retry_count=0, state PLL_RST.
  - lock_loss_count is not incremented.
  - While held high, the block stays in PLL_RST, timer frozen at 0.
- Simultaneous lock loss and soft_rst_req in RUN or RELEASE: single transition to PLL_RST; lock_loss_count increments once.
- FAULT:
  - pll_rst_n=0, domains in reset, fault=1, sticky.
  - Exits only via rst_n or soft_rst_req.
- Outputs are Moore and registered: no combinational path from pll_lock or soft_rst_req to any output.
- Invariant: ready=1 implies every domain_rst_n bit is 1.
- state_dbg encoding: PLL_RST=0, WAIT_LOCK=1, LOCK_STABLE=2, RELEASE=3, RUN=4, FAULT=5.

Decomposition:
- Package pll_seq_pkg holds:
  - typedef enum logic [2:0] seq_state_t with the encodings above;
  - a localparam for the timer width, $clog2 of max(LOCK_TIMEOUT, STAGE_GAP*(N_DOMAINS+1), PLL_RST_CYCLES, LOCK_STABLE_CYCLES)+1, computed in the module.
- One sub-module: sync_2ff, a generic 2-flop synchroniser with async active-low reset to 0. Reuse it for other async inputs.

Test Plan:
- Normal bring-up, defaults, lock asserted 10 cycles after pll_rst_n rises:
  - pll_rst_n low for 4 cycles;
  - domain_rst_n 000 -> 001 -> 011 -> 111 at 4-cycle spacing;
  - ready=1 one cycle after 111; retry_count=0.
- Lock never asserts:
  - two timeouts of 64 cycles, retry_count 0->1->2;
  - the third timeout enters FAULT: fault=1, pll_rst_n=0, state_dbg=5.
- Lock glitch in LOCK_STABLE (high 5 cycles, low 1 cycle, then high):
  - returns to WAIT_LOCK, retry_count unchanged;
  - release starts only after 8 clean consecutive cycles.
- Lock drops in RUN:
  - within 3 edges domain_rst_n=000 and ready=0;
  - lock_loss_count=1; sequence repeats and ready returns.
- soft_rst_req pulse in FAULT and in RUN:
  - fault clears; full resequence runs;
  - lock_loss_count unchanged; simultaneous loss+req increments it by exactly 1.
- rst_n asserted mid-RELEASE (after 001):
  - all outputs return to reset values asynchronously, before the next clk edge.
